// File: rtl/ctrl_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_evt_fifo
// Description : Timestamped first-word-fall-through event FIFO for the
//               register-map control window. Optional macro
//               CTRL_EVT_FIFO_DROP_OLDEST_EN makes a write into a full FIFO
//               overwrite the oldest entry instead of being dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_evt_fifo #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter logic [31:0] TS_INIT    = 32'd0
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic        evt_valid,
    input  logic [31:0] evt_dat,
    input  logic        ts_clr,
    input  logic        ctrl_fifo_rena,
    output logic        ctrl_fifo_full,
    output logic        ctrl_fifo_empty,
    output logic [63:0] ctrl_fifo_rdat,
    output logic [31:0] ctrl_fifo_dcnt,
    output logic [31:0] ovf_cnt,
    output logic [31:0] ts_now
);

    localparam int unsigned             c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]     c_FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]     c_CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0]   c_PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
`ifdef CTRL_EVT_FIFO_DROP_OLDEST_EN
    localparam logic                    c_DROP_OLDEST = 1'b1;
`else
    localparam logic                    c_DROP_OLDEST = 1'b0;
`endif

    logic [63:0]           r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_cnt;
    logic                  r_full;
    logic                  r_empty;
    logic [63:0]           r_rdat;
    logic [31:0]           r_ovf;
    logic [31:0]           r_ts;

    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_ovf;
    logic                  w_wr;
    logic                  w_rd_adv;
    logic [63:0]           w_entry;
    logic [DEPTH_LOG2-1:0] w_rd_nxt;
    logic [DEPTH_LOG2:0]   w_cnt_nxt;
    logic [63:0]           w_rdat_nxt;

    assign w_pop     = ctrl_fifo_rena && !r_empty;
    assign w_push_ok = evt_valid && (!r_full || w_pop);
    assign w_ovf     = evt_valid && r_full && !w_pop;
    assign w_wr      = w_push_ok || (c_DROP_OLDEST && w_ovf);
    assign w_rd_adv  = w_pop || (c_DROP_OLDEST && w_ovf);
    assign w_entry   = {r_ts, evt_dat};
    assign w_rd_nxt  = w_rd_adv ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push_ok && !w_pop) begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
        end else if (!w_push_ok && w_pop) begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
    end

    // Head must be valid the cycle after any edge, so forward the word being
    // written when it lands in the slot that becomes the new head.
    always_comb begin
        w_rdat_nxt = r_rdat;
        if (w_cnt_nxt != '0) begin
            if (w_wr && (w_rd_nxt == r_wr_ptr)) begin
                w_rdat_nxt = w_entry;
            end else begin
                w_rdat_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_rdat   <= 64'd0;
            r_ovf    <= 32'd0;
            r_ts     <= TS_INIT;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            r_cnt    <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == c_FULL_CNT);
            r_empty  <= (w_cnt_nxt == '0);
            r_rdat   <= w_rdat_nxt;
            if (w_ovf && (r_ovf != 32'hFFFF_FFFF)) begin
                r_ovf <= r_ovf + 32'd1;
            end
            r_ts     <= ts_clr ? 32'd0 : (r_ts + 32'd1);
        end
    end

    assign ctrl_fifo_full  = r_full;
    assign ctrl_fifo_empty = r_empty;
    assign ctrl_fifo_rdat  = r_rdat;
    assign ctrl_fifo_dcnt  = {{(31 - DEPTH_LOG2){1'b0}}, r_cnt};
    assign ovf_cnt         = r_ovf;
    assign ts_now          = r_ts;

endmodule
`default_nettype wire
